adc_sar_responder: RTL and testbench
====================================

ADC_SAR_RESPONDER -- requirements
Module: adc_sar_responder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, DAC settle cycles per SAR bit trial (legal 1..15).
REQ-002 Parameter DATA_W, default 8, conversion width (fixed at 8 for this block).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 convStart  input  1  active-high conversion request from the PMIC controller; the rising edge starts a conversion.
REQ-006 rd_cs  input  1  active-low read/chip-select from the PMIC controller.
REQ-007 comp_in  input  1  analog comparator result; 1 = sampled input >= DAC level.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 adcVoltage  output  8  result bus to the PMIC controller.
REQ-010 data_oe  output  1  bus drive enable, = !rd_cs.
REQ-011 dac_code  output  8  trial code to the capacitive DAC.
REQ-012 hold  output  1  sample/hold control; 0 = track, 1 = hold.

Function
REQ-013 FSM states: IDLE, SAMPLE, TRIAL, DONE.
REQ-014 convStart rising edge = convStart high while the registered previous value is 0; the previous-value register resets to 0.
REQ-015 IDLE: busy=0, hold=0, dac_code=0x00; a rising edge in cycle N moves the FSM to SAMPLE at N+1.
REQ-016 SAMPLE lasts exactly 1 cycle: busy=1, hold=1, bit index=7, working register=0x00.
REQ-017 TRIAL: dac_code = working register OR (1<<bit index); held for SETTLE_CYCLES cycles.
REQ-018 comp_in is sampled only in the last settle cycle of each trial: if 1, the trial bit is kept in the working register; otherwise it is cleared.
REQ-019 After the bit-0 trial, the FSM enters DONE for 1 cycle: result register <= working register, busy=1, hold=1.
REQ-020 Next cycle: IDLE with busy=0. Timing for an edge in cycle N: busy high N+1 .. N+2+8*SETTLE_CYCLES inclusive, low at N+3+8*SETTLE_CYCLES.
REQ-021 adcVoltage = result register when rd_cs=0, else 0x00 (combinational from a registered value).
REQ-022 rd_cs low during a conversion returns the previous result; the result register is never partially updated.
REQ-023 convStart edges while the FSM is not in IDLE are ignored; convStart held high does not retrigger.
REQ-024 An edge in the same cycle the FSM returns to IDLE is honoured.

Reset
REQ-025 reset asynchronously forces: FSM=IDLE, busy=0, hold=0, dac_code=0x00, result=0x00, working=0x00, settle counter=0, previous-convStart=0.
REQ-026 Reset mid-conversion aborts the conversion with no result update; the first edge after release starts a fresh conversion.

Configuration
REQ-027 Macro ADC_SAR_RESPONDER_OVERRUN_EN defined: adds output overrun (1 bit); set when a convStart edge occurs while not IDLE, cleared by reset or by a read (rd_cs low for 1 cycle).
REQ-028 Macro undefined: no overrun port; the ignored edges are behaviourally identical.

Structure
REQ-029 Package adc_sar_pkg holds the state enum, the ADC_W=8 constant, and the settle-counter width.
REQ-030 One sub-module: adc_sar_step (working register, bit index, trial/keep logic); the FSM, edge detection and bus logic stay in the top.

Verification (comparator model: comp_in = vin >= dac_code)
REQ-031 vin=0xA5, SETTLE_CYCLES=2, edge at N -> busy rises at N+1, falls after N+18; rd_cs=0 afterwards gives adcVoltage=0xA5, data_oe=1.
REQ-032 vin=0x00 and vin=0xFF -> results 0x00 and 0xFF; dac_code sequence for 0xFF is 0x80, 0xC0, ..., 0xFF.
REQ-033 Second edge mid-conversion with vin changed to 0x10 -> first result unaffected, no extra busy period; with the macro, overrun=1 until the next read.
REQ-034 rd_cs=0 during a conversion with previous result 0x3C -> adcVoltage=0x3C throughout; rd_cs=1 -> 0x00, data_oe=0.
REQ-035 reset pulsed at trial bit 4 -> busy=0 and result unchanged at 0x00 immediately; a new edge with vin=0x5A -> 0x5A.
REQ-036 SETTLE_CYCLES=1 -> busy high 10 cycles; comp_in toggled in non-sampling settle cycles with SETTLE_CYCLES=3 has no effect.

Source files
------------

// File: rtl/adc_sar_pkg.sv
// adc_sar_pkg: shared constants and FSM state type for the SAR ADC responder.
package adc_sar_pkg;
    localparam int ADC_W    = 8;
    localparam int SETTLE_W = 4;
    localparam int IDX_W    = $clog2(ADC_W);
    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_TRIAL, S_DONE} sar_state_e;
endpackage

// File: rtl/adc_sar_step.sv
// adc_sar_step: SAR working register and bit index; forms each trial code and keeps or drops the trial bit.
module adc_sar_step
    import adc_sar_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             keep_en_i,
    input  logic             comp_i,
    output logic [ADC_W-1:0] work_o,
    output logic [ADC_W-1:0] trial_o,
    output logic             last_bit_o
);
    logic [ADC_W-1:0] work_q, work_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    always_comb begin
        trial_o    = work_q | (ADC_W'(1) << idx_q);
        last_bit_o = idx_q == '0;
        work_d     = load_i ? '0 : keep_en_i ? (comp_i ? trial_o : work_q) : work_q;
        idx_d      = load_i ? IDX_W'(ADC_W - 1) : (keep_en_i && !last_bit_o) ? idx_q - 1'b1 : idx_q;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            work_q <= '0;
            idx_q  <= IDX_W'(ADC_W - 1);
        end else begin
            work_q <= work_d;
            idx_q  <= idx_d;
        end
    end
    assign work_o = work_q;
endmodule

// File: rtl/adc_sar_responder.sv
// adc_sar_responder: 8-bit SAR conversion sequencer with PMIC read bus.
// Define ADC_SAR_RESPONDER_OVERRUN_EN to add the overrun flag output.
module adc_sar_responder
    import adc_sar_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int DATA_W        = ADC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              convStart,
    input  logic              rd_cs,
    input  logic              comp_in,
    output logic              busy,
    output logic [DATA_W-1:0] adcVoltage,
    output logic              data_oe,
    output logic [DATA_W-1:0] dac_code,
    output logic              hold
`ifdef ADC_SAR_RESPONDER_OVERRUN_EN
    ,
    output logic              overrun
`endif
);
    sar_state_e        state_q, state_d;
    logic              conv_q;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [ADC_W-1:0]  result_q, result_d, work, trial;
    logic              last_bit, conv_edge, settle_done, keep_en;

    assign conv_edge   = convStart && !conv_q;
    assign settle_done = cnt_q == SETTLE_W'(SETTLE_CYCLES - 1);
    assign keep_en     = state_q == S_TRIAL && settle_done;

    adc_sar_step u_step (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (state_q == S_SAMPLE),
        .keep_en_i  (keep_en),
        .comp_i     (comp_in),
        .work_o     (work),
        .trial_o    (trial),
        .last_bit_o (last_bit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE:   state_d = conv_edge ? S_SAMPLE : S_IDLE;
            S_SAMPLE: begin
                state_d = S_TRIAL;
                cnt_d   = '0;
            end
            S_TRIAL: begin
                cnt_d   = settle_done ? '0 : cnt_q + 1'b1;
                state_d = (settle_done && last_bit) ? S_DONE : S_TRIAL;
            end
            S_DONE: begin
                state_d  = S_IDLE;
                result_d = work;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            conv_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            conv_q   <= convStart;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy       = state_q != S_IDLE;
    assign hold       = busy;
    assign dac_code   = state_q == S_TRIAL ? trial : '0;
    assign data_oe    = !rd_cs;
    assign adcVoltage = rd_cs ? '0 : result_q;

`ifdef ADC_SAR_RESPONDER_OVERRUN_EN
    logic ovr_q;
    // A stray edge wins over a same-cycle read so it is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovr_q <= 1'b0;
        else if (conv_edge && busy)
            ovr_q <= 1'b1;
        else if (!rd_cs)
            ovr_q <= 1'b0;
    end
    assign overrun = ovr_q;
`endif
endmodule

// File: tb/tb_adc_sar_responder.sv
// tb_adc_sar_responder: scoreboard bench driving three responders (SETTLE_CYCLES 1, 2, 3) against a sample/hold comparator model.
module tb_adc_sar_responder;
    logic       clk = 1'b0;
    logic       reset, convStart, rd_cs;
    logic [7:0] vin = 8'h00, vh1 = 8'h00, vh2 = 8'h00, vh3 = 8'h00;
    logic       busy1, busy2, busy3, oe1, oe2, oe3, hold1, hold2, hold3;
    logic [7:0] adc1, adc2, adc3, dac1, dac2, dac3;
    logic       comp1, comp2, comp3;
    logic [7:0] prev3 = 8'h00;
    int         cnt3 = 0, age3;
    int         nvec = 0, nerr = 0;
`ifdef ADC_SAR_RESPONDER_OVERRUN_EN
    logic       ovr1, ovr2, ovr3;
`endif

    typedef struct { logic [7:0] e1, e2, e3; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Each instance has its own track/hold; the SETTLE_CYCLES=3 comparator lies outside its sampling cycle.
    assign age3  = (dac3 != prev3) ? 0 : cnt3;
    assign comp1 = vh1 >= dac1;
    assign comp2 = vh2 >= dac2;
    assign comp3 = (age3 == 2) ? (vh3 >= dac3) : !(vh3 >= dac3);

    always @(posedge clk) begin
        if (!hold1) vh1 <= vin;
        if (!hold2) vh2 <= vin;
        if (!hold3) vh3 <= vin;
        prev3 <= dac3;
        cnt3  <= (dac3 != prev3) ? 1 : cnt3 + 1;
    end

    adc_sar_responder #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .reset(reset), .convStart(convStart), .rd_cs(rd_cs), .comp_in(comp1),
        .busy(busy1), .adcVoltage(adc1), .data_oe(oe1), .dac_code(dac1), .hold(hold1)
`ifdef ADC_SAR_RESPONDER_OVERRUN_EN
        , .overrun(ovr1)
`endif
    );
    adc_sar_responder #(.SETTLE_CYCLES(2)) u_s2 (
        .clk(clk), .reset(reset), .convStart(convStart), .rd_cs(rd_cs), .comp_in(comp2),
        .busy(busy2), .adcVoltage(adc2), .data_oe(oe2), .dac_code(dac2), .hold(hold2)
`ifdef ADC_SAR_RESPONDER_OVERRUN_EN
        , .overrun(ovr2)
`endif
    );
    adc_sar_responder #(.SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .reset(reset), .convStart(convStart), .rd_cs(rd_cs), .comp_in(comp3),
        .busy(busy3), .adcVoltage(adc3), .data_oe(oe3), .dac_code(dac3), .hold(hold3)
`ifdef ADC_SAR_RESPONDER_OVERRUN_EN
        , .overrun(ovr3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic start(input logic [7:0] v, input bit push, input bit keep_high);
        vin       = v;
        convStart = 1'b1;
        if (push) sb.push_back('{v, v, v});
        tick;
        if (!keep_high) convStart = 1'b0;
    endtask

    task automatic wait_idle(output int n1, output int n2, output int n3);
        n1 = 0; n2 = 0; n3 = 0;
        for (int i = 0; i < 100; i++) begin
            if (!(busy1 || busy2 || busy3)) return;
            n1 += int'(busy1);
            n2 += int'(busy2);
            n3 += int'(busy3);
            tick;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic read_back;
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        rd_cs = 1'b0;
        tick;
        chk("adc_s1", adc1, e.e1);
        chk("adc_s2", adc2, e.e2);
        chk("adc_s3", adc3, e.e3);
        chk("oe_on", oe2, 1);
        rd_cs = 1'b1;
        tick;
        chk("adc_off", adc2, 0);
        chk("oe_off", oe2, 0);
    endtask

    initial begin
        int n1, n2, n3;
        reset = 1'b1; convStart = 1'b0; rd_cs = 1'b1;
        tick; tick;
        chk("rst_busy", busy2, 0);
        chk("rst_hold", hold2, 0);
        chk("rst_dac", dac2, 0);
        rd_cs = 1'b0; #1;
        chk("rst_result", adc2, 0);
        chk("rst_oe", oe2, 1);
        rd_cs = 1'b1;
        reset = 1'b0;
        tick;

        start(8'hA5, 1, 0);
        chk("sample_busy", busy2, 1);
        chk("sample_hold", hold2, 1);
        chk("sample_dac", dac2, 0);
        wait_idle(n1, n2, n3);
        chk("busy_len_s1", n1, 10);
        chk("busy_len_s2", n2, 18);
        chk("busy_len_s3", n3, 26);
        read_back;

        start(8'hFF, 1, 0);
        for (int k = 0; k < 8; k++) begin
            tick;
            chk("dac_seq", dac2, 8'(16'hFF00 >> (k + 1)));
            tick;
        end
        wait_idle(n1, n2, n3);
        read_back;

        start(8'h00, 1, 1);
        wait_idle(n1, n2, n3);
        repeat (3) tick;
        chk("no_retrigger_held", busy2, 0);
        convStart = 1'b0;
        read_back;

        start(8'h3C, 1, 0);
        repeat (4) tick;
        vin = 8'h10; convStart = 1'b1;
        tick;
        convStart = 1'b0;
`ifdef ADC_SAR_RESPONDER_OVERRUN_EN
        chk("overrun_set", ovr2, 1);
`endif
        wait_idle(n1, n2, n3);
        chk("ignored_edge_len", n2, 13);
        repeat (3) tick;
        chk("ignored_edge_idle", busy2, 0);
`ifdef ADC_SAR_RESPONDER_OVERRUN_EN
        chk("overrun_hold", ovr2, 1);
`endif
        read_back;
`ifdef ADC_SAR_RESPONDER_OVERRUN_EN
        chk("overrun_clr", ovr2, 0);
`endif

        rd_cs = 1'b0;
        start(8'h77, 1, 0);
        for (int i = 0; i < 40 && busy2; i++) begin
            chk("rd_during_conv", adc2, 8'h3C);
            tick;
        end
        rd_cs = 1'b1; #1;
        chk("rd_high_adc", adc2, 0);
        chk("rd_high_oe", oe2, 0);
        wait_idle(n1, n2, n3);
        read_back;

        start(8'h99, 0, 0);
        repeat (7) tick;
        chk("at_bit4", dac2 & 8'h1F, 8'h10);
        reset = 1'b1; #1;
        chk("abort_busy", busy2, 0);
        chk("abort_dac", dac2, 0);
        rd_cs = 1'b0; #1;
        chk("abort_result", adc2, 0);
        rd_cs = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        start(8'h5A, 1, 0);
        wait_idle(n1, n2, n3);
        read_back;

        start(8'h21, 0, 0);
        for (int i = 0; i < 40 && busy2; i++) tick;
        chk("back_idle", busy2, 0);
        vin = 8'h4E; convStart = 1'b1;
        tick;
        convStart = 1'b0;
        chk("reentry_busy", busy2, 1);
        sb.push_back('{8'h4E, 8'h4E, 8'h21});
        wait_idle(n1, n2, n3);
        read_back;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
